register_access_arbiter: RTL

- Shares a single `register` instance (funsel/e/i/q interface, 16-bit) among NReq requesters using round-robin arbitration.
- Sequences each granted operation as a three-phase transaction: setup, enable pulse, acknowledge.
- Guarantees funsel and i are stable before e rises. The register's increment and decrement act on the e rising edge; clear and load are level-sensitive on e.
- Sits between the control-unit requesters and the shared register.

---
 rtl/register_access_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/register_access_arbiter.sv
// register_access_arbiter
//   Round-robin arbiter that shares one 16-bit `register` (funsel/e/i
//   interface) among NReq requesters. Each granted operation runs as a
//   fixed sequence: IDLE (arbitrate) -> SETUP -> PULSE -> DONE.
//   funsel and i are driven during SETUP, so they are stable before e
//   rises in PULSE.
//
// Ports
//   clk, rst     : clock; asynchronous active-high reset
//   req          : per-requester level request, held until ack
//   funsel_in    : requester k op at [2k+1:2k] (00 clr, 01 load, 10 dec, 11 inc)
//   data_in      : requester k load data at [NBits*k +: NBits]
//   grant        : one-hot current owner, zero when idle
//   ack          : one-cycle completion pulse to the owner (in DONE)
//   busy         : high in SETUP, PULSE, DONE
//   reg_funsel, reg_e, reg_i : drive the shared register
module register_access_arbiter #(
  parameter int NBits = 16,
  parameter int NReq  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NReq-1:0]       req,
  input  logic [2*NReq-1:0]     funsel_in,
  input  logic [NBits*NReq-1:0] data_in,
  output logic [NReq-1:0]       grant,
  output logic [NReq-1:0]       ack,
  output logic                  busy,
  output logic [1:0]            reg_funsel,
  output logic                  reg_e,
  output logic [NBits-1:0]      reg_i
);

  localparam int PW = (NReq > 1) ? $clog2(NReq) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, DONE} state_t;

  state_t  state;
  logic [PW-1:0] ptr;    // highest-priority requester for the next IDLE
  logic [PW-1:0] owner;  // winner of the transaction in flight

  // Packed views: element k of each array lines up with requester k's slice.
  logic [NReq-1:0][1:0]       fs;
  logic [NReq-1:0][NBits-1:0] dt;
  assign fs = funsel_in;
  assign dt = data_in;

  // Round-robin search: first set req at or above ptr, wrapping modulo NReq.
  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW:0]   scan;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int i = 0; i < NReq; i++) begin
      scan = {1'b0, ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(NReq)) scan = scan - (PW+1)'(NReq);
      if (!win_vld && req[scan[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
  end

  logic [NReq-1:0] win_onehot;
  assign win_onehot = {{(NReq-1){1'b0}}, 1'b1} << win_idx;

  // Outputs are registered and loaded with the value for the state being
  // entered. The winner's funsel/data are captured straight into reg_funsel
  // and reg_i at arbitration; they are not touched again until the next
  // arbitration, so later changes on the inputs cannot reach the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      grant      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      reg_funsel <= 2'b00;
      reg_e      <= 1'b0;
      reg_i      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack   <= '0;
          reg_e <= 1'b0;
          if (win_vld) begin
            owner      <= win_idx;
            grant      <= win_onehot;
            busy       <= 1'b1;
            reg_funsel <= fs[win_idx];
            reg_i      <= dt[win_idx];
            state      <= SETUP;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        SETUP: begin
          reg_e <= 1'b1;
          state <= PULSE;
        end
        PULSE: begin
          reg_e <= 1'b0;
          ack   <= grant;
          state <= DONE;
        end
        DONE: begin
          ack   <= '0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (owner == PW'(NReq-1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
